// File: rtl/res_bram_pkg.sv
// Shared types and defaults for the result-BRAM port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package res_bram_pkg;

  localparam int RES_BRAM_DEPTH = 10;
  localparam int RES_DATA_WIDTH = 32;
  localparam int WR_RUN_W       = 4;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } gnt_t;

endpackage

// File: rtl/res_bram_rd_pipe.sv
// Read-return pipeline: turns a read grant into a valid pulse carrying BRAM data.
// Latency: 1 cycle from grant, or 2 with RES_BRAM_ARB_RD_REG_EN (data registered).
// Backpressure: none; one valid per granted read, in grant order.
module res_bram_rd_pipe
  import res_bram_pkg::*;
#(
  parameter int DATA_WIDTH = RES_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_gnt,
  input  logic [DATA_WIDTH-1:0] i_bram_dout,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

`ifdef RES_BRAM_ARB_RD_REG_EN
  logic                  r_vld_s1;
  logic                  r_vld_s2;
  logic [DATA_WIDTH-1:0] r_dat;

  // Stage 1 marks BRAM output valid; stage 2 holds registered data with its valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_s1 <= 1'b0;
      r_vld_s2 <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_vld_s1 <= i_rd_gnt;
      r_vld_s2 <= r_vld_s1;
      r_dat    <= r_vld_s1 ? i_bram_dout : '0;
    end
  end

  assign o_rd_valid = r_vld_s2;
  assign o_rd_data  = r_dat;
`else
  logic r_rd_pipe;

  // Track which cycle's BRAM output belongs to a granted read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_pipe <= 1'b0;
    end else begin
      r_rd_pipe <= i_rd_gnt;
    end
  end

  // Data is forced to zero outside a valid cycle so stale BRAM output never leaks.
  assign o_rd_valid = r_rd_pipe;
  assign o_rd_data  = r_rd_pipe ? i_bram_dout : '0;
`endif

endmodule

// File: rtl/res_bram_port_arbiter.sv
// Shares one single-port result BRAM between the PE writer and the fetch-unit reader.
// Latency: grants combinational; read data 1 cycle after grant (2 with RES_BRAM_ARB_RD_REG_EN).
// Backpressure: writes win, but after MAX_WR_RUN writes past a waiting read the read is granted.
module res_bram_port_arbiter
  import res_bram_pkg::*;
#(
  parameter int BRAM_DEPTH = RES_BRAM_DEPTH,
  parameter int DATA_WIDTH = RES_DATA_WIDTH,
  parameter int MAX_WR_RUN = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  pe_wr_req,
  input  logic [BRAM_DEPTH-1:0] pe_wr_addr,
  input  logic [DATA_WIDTH-1:0] pe_wr_data,
  output logic                  pe_wr_gnt,
  input  logic                  fu_rd_req,
  input  logic [BRAM_DEPTH-1:0] fu_rd_addr,
  output logic                  fu_rd_gnt,
  output logic                  fu_rd_valid,
  output logic [DATA_WIDTH-1:0] fu_rd_data,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [BRAM_DEPTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  localparam logic [WR_RUN_W-1:0] MAX_RUN = WR_RUN_W'(MAX_WR_RUN);

  logic [WR_RUN_W-1:0] r_wr_run;
  gnt_t                w_gnt;

  // Pick the winner: writes first unless a waiting read has already been passed MAX_RUN times.
  always_comb begin
    w_gnt = GNT_NONE;
    if (ARESET) begin
      w_gnt = GNT_NONE;
    end else if (pe_wr_req && (!fu_rd_req || (r_wr_run < MAX_RUN))) begin
      w_gnt = GNT_WR;
    end else if (fu_rd_req) begin
      w_gnt = GNT_RD;
    end
  end

  assign pe_wr_gnt = (w_gnt == GNT_WR);
  assign fu_rd_gnt = (w_gnt == GNT_RD);
  assign bram_en   = pe_wr_gnt | fu_rd_gnt;
  assign bram_we   = pe_wr_gnt;

  // Steer the granted requester onto the BRAM port; park address/data at zero when idle.
  always_comb begin
    bram_addr = '0;
    bram_din  = '0;
    if (pe_wr_gnt) begin
      bram_addr = pe_wr_addr;
      bram_din  = pe_wr_data;
    end else if (fu_rd_gnt) begin
      bram_addr = fu_rd_addr;
    end
  end

  // Count writes that overtook a waiting read; any read grant or idle reader restarts the count.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_run <= '0;
    end else if (!fu_rd_req || fu_rd_gnt) begin
      r_wr_run <= '0;
    end else if (pe_wr_gnt && (r_wr_run < MAX_RUN)) begin
      r_wr_run <= r_wr_run + WR_RUN_W'(1);
    end
  end

  res_bram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .i_clk       (ACLK),
    .i_rst       (ARESET),
    .i_rd_gnt    (fu_rd_gnt),
    .i_bram_dout (bram_dout),
    .o_rd_valid  (fu_rd_valid),
    .o_rd_data   (fu_rd_data)
  );

endmodule
